l1d_tag_update_sequencer: RTL and testbench

Sequences every write to the L1 data cache tag/valid arrays. It arbitrates between line-fill requests and invalidate requests from the L2 interface. Each request runs as a lookup cycle on the tag stage's snoop read port (and LRU fill port), followed by a single tag-update cycle. The block drives the tag stage's LRU-fill, snoop-read and one-hot tag-update ports, so no other logic writes the tags.

---
 rtl/l1d_tag_update_sequencer.sv | 187 ++++++++++++++++++
 tb/tb_l1d_tag_update_sequencer.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/l1d_tag_update_sequencer.sv
// L1D tag update sequencer: arbitrates line-fill and invalidate requests
// from the L2 side and turns each into a lookup cycle followed by a single
// tag-update cycle on the tag stage, so it is the only writer of the tags.
module l1d_tag_update_sequencer #(
    parameter  int NUM_WAYS  = 4,
    parameter  int NUM_SETS  = 64,
    parameter  int TAG_WIDTH = 20,
    localparam int WAY_BITS  = $clog2(NUM_WAYS),
    localparam int SET_BITS  = $clog2(NUM_SETS)
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          fill_req_valid,
    output logic                          fill_req_ready,
    input  logic [SET_BITS-1:0]           fill_req_set,
    input  logic [TAG_WIDTH-1:0]          fill_req_tag,
    input  logic                          inval_req_valid,
    output logic                          inval_req_ready,
    input  logic [SET_BITS-1:0]           inval_req_set,
    input  logic [TAG_WIDTH-1:0]          inval_req_tag,
    output logic                          lru_fill_en,
    output logic [SET_BITS-1:0]           lru_fill_set,
    input  logic [WAY_BITS-1:0]           lru_fill_way,
    output logic                          snoop_en,
    output logic [SET_BITS-1:0]           snoop_set,
    input  logic [NUM_WAYS-1:0]           snoop_valid,
    input  logic [NUM_WAYS*TAG_WIDTH-1:0] snoop_tag,
    output logic [NUM_WAYS-1:0]           tag_update_en_oh,
    output logic [SET_BITS-1:0]           tag_update_set,
    output logic [TAG_WIDTH-1:0]          tag_update_tag,
    output logic                          tag_update_valid,
    output logic                          fill_done,
    output logic [WAY_BITS-1:0]           fill_done_way,
    output logic                          inval_done,
    output logic                          inval_hit,
    output logic                          busy
);

    typedef enum logic [2:0] {
        IDLE        = 3'd0,
        FILL_LOOKUP = 3'd1,
        FILL_WRITE  = 3'd2,
        INV_LOOKUP  = 3'd3,
        INV_WRITE   = 3'd4
    } state_t;

    // last_grant encoding: 0 = fill was granted last, 1 = invalidate was.
    localparam logic GRANT_FILL  = 1'b0;
    localparam logic GRANT_INVAL = 1'b1;

    state_t               state_q, state_d;
    logic                 last_grant_q, last_grant_d;
    logic [SET_BITS-1:0]  req_set_q, req_set_d;
    logic [TAG_WIDTH-1:0] req_tag_q, req_tag_d;

    logic                 grant_fill, grant_inval;
    logic [NUM_WAYS-1:0]  hit;
    logic [WAY_BITS-1:0]  hit_way;
    logic [WAY_BITS-1:0]  fill_way;
    logic [NUM_WAYS-1:0]  fill_way_oh;

    // Round-robin grant between the two requesters, only while idle.
    always_comb begin
        grant_fill  = 1'b0;
        grant_inval = 1'b0;
        if (state_q == IDLE) begin
            grant_inval = inval_req_valid &
                          (!fill_req_valid || last_grant_q == GRANT_FILL);
            grant_fill  = fill_req_valid &
                          (!inval_req_valid || last_grant_q == GRANT_INVAL);
        end
    end

    // Tag compare against the captured request and victim-way selection.
    always_comb begin
        hit         = '0;
        hit_way     = '0;
        fill_way_oh = '0;
        for (int w = 0; w < NUM_WAYS; w++) begin
            hit[w] = snoop_valid[w] &&
                     (snoop_tag[w*TAG_WIDTH +: TAG_WIDTH] == req_tag_q);
        end
        // Scan downward so the lowest-indexed hit wins.
        for (int w = NUM_WAYS - 1; w >= 0; w--) begin
            if (hit[w]) hit_way = WAY_BITS'(w);
        end
        // Re-use an existing copy of the tag so a set never holds duplicates.
        fill_way              = (|hit) ? hit_way : lru_fill_way;
        fill_way_oh[fill_way] = 1'b1;
    end

    // State, arbitration history and captured request registers.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q      <= IDLE;
            last_grant_q <= GRANT_FILL;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
        end
        req_set_q <= req_set_d;
        req_tag_q <= req_tag_d;
    end

    // Next-state and capture logic.
    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        req_set_d    = req_set_q;
        req_tag_d    = req_tag_q;
        case (state_q)
            IDLE: begin
                if (grant_inval) begin
                    state_d      = INV_LOOKUP;
                    last_grant_d = GRANT_INVAL;
                    req_set_d    = inval_req_set;
                    req_tag_d    = inval_req_tag;
                end else if (grant_fill) begin
                    state_d      = FILL_LOOKUP;
                    last_grant_d = GRANT_FILL;
                    req_set_d    = fill_req_set;
                    req_tag_d    = fill_req_tag;
                end
            end
            FILL_LOOKUP: state_d = FILL_WRITE;
            FILL_WRITE:  state_d = IDLE;
            INV_LOOKUP:  state_d = INV_WRITE;
            INV_WRITE:   state_d = IDLE;
            default:     state_d = IDLE;
        endcase
    end

    // Output decode; everything is forced low while reset is held.
    always_comb begin
        fill_req_ready   = 1'b0;
        inval_req_ready  = 1'b0;
        lru_fill_en      = 1'b0;
        lru_fill_set     = '0;
        snoop_en         = 1'b0;
        snoop_set        = '0;
        tag_update_en_oh = '0;
        tag_update_set   = '0;
        tag_update_tag   = '0;
        tag_update_valid = 1'b0;
        fill_done        = 1'b0;
        fill_done_way    = '0;
        inval_done       = 1'b0;
        inval_hit        = 1'b0;
        busy             = 1'b0;
        if (reset) begin
            busy = (state_q != IDLE);
            case (state_q)
                IDLE: begin
                    fill_req_ready  = grant_fill;
                    inval_req_ready = grant_inval;
                end
                FILL_LOOKUP: begin
                    lru_fill_en  = 1'b1;
                    lru_fill_set = req_set_q;
                    snoop_en     = 1'b1;
                    snoop_set    = req_set_q;
                end
                FILL_WRITE: begin
                    tag_update_en_oh = fill_way_oh;
                    tag_update_set   = req_set_q;
                    tag_update_tag   = req_tag_q;
                    tag_update_valid = 1'b1;
                    fill_done        = 1'b1;
                    fill_done_way    = fill_way;
                end
                INV_LOOKUP: begin
                    snoop_en  = 1'b1;
                    snoop_set = req_set_q;
                end
                INV_WRITE: begin
                    tag_update_en_oh = hit;
                    tag_update_set   = req_set_q;
                    tag_update_tag   = req_tag_q;
                    inval_done       = 1'b1;
                    inval_hit        = |hit;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_l1d_tag_update_sequencer.sv
// Directed bench for l1d_tag_update_sequencer.
module tb_l1d_tag_update_sequencer;

    localparam int NW = 4;
    localparam int TW = 20;
    localparam int SB = 6;
    localparam int WB = 2;

    logic            clk = 1'b0;
    logic            reset;
    logic            fill_req_valid, inval_req_valid;
    logic            fill_req_ready, inval_req_ready;
    logic [SB-1:0]   fill_req_set, inval_req_set;
    logic [TW-1:0]   fill_req_tag, inval_req_tag;
    logic            lru_fill_en, snoop_en;
    logic [SB-1:0]   lru_fill_set, snoop_set, tag_update_set;
    logic [WB-1:0]   lru_fill_way, fill_done_way;
    logic [NW-1:0]   snoop_valid, tag_update_en_oh;
    logic [NW*TW-1:0] snoop_tag;
    logic [TW-1:0]   tag_update_tag;
    logic            tag_update_valid, fill_done, inval_done, inval_hit, busy;

    int n_cmp = 0;
    int n_err = 0;

    l1d_tag_update_sequencer #(.NUM_WAYS(NW), .NUM_SETS(64), .TAG_WIDTH(TW)) dut (
        .clk(clk), .reset(reset),
        .fill_req_valid(fill_req_valid), .fill_req_ready(fill_req_ready),
        .fill_req_set(fill_req_set), .fill_req_tag(fill_req_tag),
        .inval_req_valid(inval_req_valid), .inval_req_ready(inval_req_ready),
        .inval_req_set(inval_req_set), .inval_req_tag(inval_req_tag),
        .lru_fill_en(lru_fill_en), .lru_fill_set(lru_fill_set), .lru_fill_way(lru_fill_way),
        .snoop_en(snoop_en), .snoop_set(snoop_set),
        .snoop_valid(snoop_valid), .snoop_tag(snoop_tag),
        .tag_update_en_oh(tag_update_en_oh), .tag_update_set(tag_update_set),
        .tag_update_tag(tag_update_tag), .tag_update_valid(tag_update_valid),
        .fill_done(fill_done), .fill_done_way(fill_done_way),
        .inval_done(inval_done), .inval_hit(inval_hit), .busy(busy)
    );

    always #5 clk = ~clk;

    // Every output concatenated, for all-zero checks.
    wire [63:0] all_out = 64'({fill_req_ready, inval_req_ready, lru_fill_en, lru_fill_set,
                               snoop_en, snoop_set, tag_update_en_oh, tag_update_set,
                               tag_update_tag, tag_update_valid, fill_done, fill_done_way,
                               inval_done, inval_hit, busy});

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    initial begin
        reset = 1'b0;
        fill_req_valid = 1'b0; inval_req_valid = 1'b0;
        fill_req_set = '0; fill_req_tag = '0;
        inval_req_set = '0; inval_req_tag = '0;
        lru_fill_way = '0; snoop_valid = '0; snoop_tag = '0;

        // Reset state: pending requests must not see ready while reset is held.
        step(); step();
        fill_req_valid = 1'b1; inval_req_valid = 1'b1;
        settle();
        check("reset_all_zero", all_out, 64'd0);
        fill_req_valid = 1'b0; inval_req_valid = 1'b0;
        reset = 1'b1;
        step();

        // Fill to an empty set.
        fill_req_valid = 1'b1; fill_req_set = 6'd5; fill_req_tag = 20'h00123;
        settle();
        check("fill1_ready", {fill_req_ready, inval_req_ready}, 2'b10);
        check("fill1_idle_busy", busy, 1'b0);
        step();
        fill_req_valid = 1'b0; fill_req_set = 6'd63; fill_req_tag = 20'hFFFFF;
        settle();
        check("fill1_lookup", {lru_fill_en, snoop_en, lru_fill_set, snoop_set, busy},
              {1'b1, 1'b1, 6'd5, 6'd5, 1'b1});
        check("fill1_lookup_noupd", {tag_update_en_oh, fill_done}, 5'd0);
        step();
        snoop_valid = 4'b0000; lru_fill_way = 2'd2;
        settle();
        check("fill1_en_oh", tag_update_en_oh, 4'b0100);
        check("fill1_update", {tag_update_set, tag_update_tag, tag_update_valid},
              {6'd5, 20'h00123, 1'b1});
        check("fill1_done", {fill_done, fill_done_way, lru_fill_en, snoop_en}, {1'b1, 2'd2, 2'b00});
        step();
        check("fill1_back_idle", {busy, fill_done, tag_update_en_oh}, 6'd0);

        // Duplicate fill: way 1 already holds the tag, way 0 holds another tag.
        fill_req_valid = 1'b1; fill_req_set = 6'd5; fill_req_tag = 20'h00123;
        settle();
        check("dup_ready", fill_req_ready, 1'b1);
        step();
        fill_req_valid = 1'b0;
        step();
        snoop_valid = 4'b0011; lru_fill_way = 2'd3;
        snoop_tag = {20'h00123, 20'h00123, 20'h00123, 20'h00456};
        snoop_valid = 4'b0011;
        settle();
        check("dup_en_oh", tag_update_en_oh, 4'b0010);
        check("dup_done_way", {fill_done, fill_done_way, tag_update_valid}, {1'b1, 2'd1, 1'b1});
        step();

        // Invalidate with hits in ways 0 and 3 (way 1 has the tag but is invalid).
        inval_req_valid = 1'b1; inval_req_set = 6'd9; inval_req_tag = 20'h00ABC;
        settle();
        check("inv_ready", {fill_req_ready, inval_req_ready}, 2'b01);
        step();
        inval_req_valid = 1'b0;
        settle();
        check("inv_lookup", {lru_fill_en, snoop_en, snoop_set, lru_fill_set},
              {1'b0, 1'b1, 6'd9, 6'd0});
        step();
        snoop_tag = {20'h00ABC, 20'h00111, 20'h00ABC, 20'h00ABC};
        snoop_valid = 4'b1101;
        settle();
        check("inv_en_oh", tag_update_en_oh, 4'b1001);
        check("inv_update", {tag_update_set, tag_update_tag, tag_update_valid},
              {6'd9, 20'h00ABC, 1'b0});
        check("inv_done_hit", {inval_done, inval_hit, fill_done}, 3'b110);
        step();

        // Invalidate with no match.
        inval_req_valid = 1'b1; inval_req_set = 6'd9; inval_req_tag = 20'h00ABD;
        step();
        inval_req_valid = 1'b0;
        step();
        settle();
        check("inv_miss", {tag_update_en_oh, inval_done, inval_hit}, {4'b0000, 1'b1, 1'b0});
        step();

        // Arbitration: both valid from reset release.
        reset = 1'b0;
        step();
        fill_req_valid = 1'b1; inval_req_valid = 1'b1;
        fill_req_set = 6'd1; inval_req_set = 6'd2;
        snoop_valid = '0;
        reset = 1'b1;
        settle();
        for (int c = 0; c < 12; c++) begin
            logic exp_inv, exp_fill;
            exp_inv  = (c % 3 == 0) && ((c / 3) % 2 == 0);
            exp_fill = (c % 3 == 0) && ((c / 3) % 2 == 1);
            check($sformatf("arb_c%0d", c), {inval_req_ready, fill_req_ready}, {exp_inv, exp_fill});
            step();
        end
        fill_req_valid = 1'b0; inval_req_valid = 1'b0;
        step(); step(); step();

        // Reset during FILL_LOOKUP.
        fill_req_valid = 1'b1; fill_req_set = 6'd3; fill_req_tag = 20'h00777;
        settle();
        check("rst_mid_grant", fill_req_ready, 1'b1);
        step();
        settle();
        check("rst_mid_lookup", lru_fill_en, 1'b1);
        reset = 1'b0;
        step();
        settle();
        check("rst_mid_zero", all_out, 64'd0);
        step();
        check("rst_mid_zero2", all_out, 64'd0);
        reset = 1'b1;
        settle();
        check("rst_release_ready", {fill_req_ready, busy}, 2'b10);
        step();
        fill_req_valid = 1'b0;
        settle();
        check("rst_relookup_nodone", {lru_fill_en, fill_done}, 2'b10);
        step();
        snoop_valid = '0; lru_fill_way = 2'd0;
        settle();
        check("rst_refill_done", {fill_done, tag_update_tag}, {1'b1, 20'h00777});
        step();

        // Same-set back-to-back fills.
        fill_req_valid = 1'b1; fill_req_set = 6'd7; fill_req_tag = 20'h00011;
        step();
        fill_req_valid = 1'b0;
        step();
        snoop_valid = 4'b0000; lru_fill_way = 2'd0;
        settle();
        check("b2b_first_en", {tag_update_en_oh, tag_update_tag}, {4'b0001, 20'h00011});
        step();
        fill_req_valid = 1'b1; fill_req_set = 6'd7; fill_req_tag = 20'h00022;
        settle();
        check("b2b_second_ready", fill_req_ready, 1'b1);
        step();
        fill_req_valid = 1'b0;
        settle();
        check("b2b_second_lookup", {snoop_en, snoop_set}, {1'b1, 6'd7});
        step();
        snoop_valid = 4'b0001; snoop_tag = {20'h0, 20'h0, 20'h0, 20'h00011}; lru_fill_way = 2'd1;
        settle();
        check("b2b_second_en", {tag_update_en_oh, tag_update_tag, fill_done_way},
              {4'b0010, 20'h00022, 2'd1});
        step();
        check("b2b_idle", busy, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
